// File: rtl/node_fifo_validready.sv
// node_fifo_validready
// Valid/ready pipeline node built around a DEPTH-entry circular buffer.
// up_ready_out, dn_valid_out and level are flop-driven, so the ready path
// between neighbouring nodes is broken; data_out is read from the buffer head.
// Optional feature: define NODE_FIFO_FLUSH_EN to add a synchronous `flush`
// input that empties the buffer (priority over push and pop).
module node_fifo_validready #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_valid_in,
  output logic             up_ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             dn_valid_out,
  input  logic             dn_ready_in,
`ifdef NODE_FIFO_FLUSH_EN
  input  logic             flush,
`endif
  output logic [LW-1:0]    level
);

  // Pointer width; DEPTH >= 2 guarantees at least one bit.
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [LW-1:0]    r_count;
  logic             r_up_ready;
  logic             r_dn_valid;

  logic             w_up_fire;
  logic             w_dn_fire;
  logic             w_flush;
  logic             w_push;
  logic [PW-1:0]    w_wp_next;
  logic [PW-1:0]    w_rp_next;
  logic [LW-1:0]    w_count_next;

  // Pointer increment that wraps at DEPTH-1, valid for non-power-of-two DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Handshake decode and next-state computation for pointers and occupancy.
  always_comb begin
`ifdef NODE_FIFO_FLUSH_EN
    w_flush = flush;
`else
    w_flush = 1'b0;
`endif
    w_up_fire = up_valid_in & r_up_ready;
    w_dn_fire = r_dn_valid & dn_ready_in;
    // A push that coincides with a flush is discarded.
    w_push    = w_up_fire & ~w_flush;

    if (w_flush) begin
      w_wp_next = '0;
    end else if (w_up_fire) begin
      w_wp_next = ptr_inc(r_wp);
    end else begin
      w_wp_next = r_wp;
    end

    if (w_flush) begin
      w_rp_next = '0;
    end else if (w_dn_fire) begin
      w_rp_next = ptr_inc(r_rp);
    end else begin
      w_rp_next = r_rp;
    end

    if (w_flush) begin
      w_count_next = '0;
    end else begin
      case ({w_up_fire, w_dn_fire})
        2'b10:   w_count_next = r_count + LW'(1);
        2'b01:   w_count_next = r_count - LW'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  // Control state and registered handshake outputs; async reset empties the node.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_up_ready <= 1'b0;
      r_dn_valid <= 1'b0;
    end else begin
      r_wp       <= w_wp_next;
      r_rp       <= w_rp_next;
      r_count    <= w_count_next;
      r_up_ready <= (w_count_next < LW'(DEPTH));
      r_dn_valid <= (w_count_next != '0);
    end
  end

  // Payload storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= data_in;
    end
  end

  assign up_ready_out = r_up_ready;
  assign dn_valid_out = r_dn_valid;
  assign level        = r_count;
  assign data_out     = r_mem[r_rp];

endmodule
